// File: rtl/ps2_key_event_queue.sv
// Queues ps2_key toggle events and replays them as paced strobe/pressed/code pulses
// that a slower core clock can sample reliably.
module ps2_key_event_queue #(
  parameter int DEPTH      = 8,
  parameter int STB_WIDTH  = 4,
  parameter int GAP_CYCLES = 48000
) (
  input  logic                       clk_48,
  input  logic                       reset_n,
  input  logic [10:0]                ps2_key,
  input  logic                       enable,
  input  logic                       clear_ovf,
  output logic                       key_strobe,
  output logic                       key_pressed,
  output logic                       key_extended,
  output logic [7:0]                 key_code,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = ((STB_WIDTH > GAP_CYCLES) ? STB_WIDTH : GAP_CYCLES) - 1;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] STB_LOAD = CNT_W'(STB_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = HAS_GAP ? CNT_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             strobe_reg, strobe_next;
  logic [9:0]       data_reg;
  logic             old_tgl_reg;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      level_reg, level_next;
  logic             overflow_reg;
  logic [9:0]       mem [DEPTH];

  logic event_in, full, pop, push_ok, drop;

  assign event_in = (ps2_key[10] != old_tgl_reg);
  assign full     = (level_reg == (AW+1)'(DEPTH));
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok  = event_in && (!full || pop);
  assign drop     = event_in && full && !pop;
  assign level_next = level_reg + (AW+1)'(push_ok) - (AW+1)'(pop);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    strobe_next = strobe_reg;
    pop         = 1'b0;
    case (state_reg)
      IDLE: begin
        strobe_next = 1'b0;
        if (enable && level_reg != '0) begin
          pop         = 1'b1;
          strobe_next = 1'b1;
          cnt_next    = STB_LOAD;
          state_next  = STROBE;
        end
      end
      STROBE: begin
        if (cnt_reg == '0) begin
          strobe_next = 1'b0;
          if (HAS_GAP) begin
            cnt_next   = GAP_LOAD;
            state_next = GAP;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      GAP: begin
        strobe_next = 1'b0;
        if (cnt_reg == '0) state_next = IDLE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      default: begin
        strobe_next = 1'b0;
        state_next  = IDLE;
      end
    endcase
  end

  // Storage carries no reset so it maps onto plain RAM; pointers define validity.
  always_ff @(posedge clk_48) begin
    if (push_ok) mem[wr_ptr_reg] <= ps2_key[9:0];
  end

  always_ff @(posedge clk_48) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      strobe_reg   <= 1'b0;
      data_reg     <= '0;
      old_tgl_reg  <= ps2_key[10];
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      strobe_reg  <= strobe_next;
      old_tgl_reg <= ps2_key[10];
      level_reg   <= level_next;
      if (pop) begin
        data_reg   <= mem[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (drop)           overflow_reg <= 1'b1;
      else if (clear_ovf) overflow_reg <= 1'b0;
    end
  end

  assign key_strobe   = strobe_reg;
  assign key_pressed  = data_reg[9];
  assign key_extended = data_reg[8];
  assign key_code     = data_reg[7:0];
  assign level        = level_reg;
  assign overflow     = overflow_reg;

endmodule
